sram_port_arbiter: RTL

- Shares one single-port synchronous SRAM between the fetch-side requester (inst) and the memory-stage requester (data).
- Both requesters use a req / addr_ok / data_ok handshake.
- Grants at most one request per cycle and routes the one-cycle-latency response back to the owning requester.
- Data requests normally win. A starvation counter forces an inst grant after a bounded run of data wins.

---
 rtl/sram_port_arbiter.sv | 114 +++++++++++
 1 files changed

// File: rtl/sram_port_arbiter.sv
// Arbitrates one single-port synchronous SRAM between an instruction-fetch
// requester and a data requester, returning each one-cycle response to its owner.
module sram_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inst_req,
  input  logic [DATA_W/8-1:0] inst_we,
  input  logic [ADDR_W-1:0]   inst_addr,
  input  logic [DATA_W-1:0]   inst_wdata,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic [DATA_W/8-1:0] data_we,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                sram_en,
  output logic [DATA_W/8-1:0] sram_we,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_wdata,
  input  logic [DATA_W-1:0]   sram_rdata
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic             grant_inst_s;
  logic             grant_data_s;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_owner_q, resp_owner_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  // Grant selection: data wins unless inst has waited through STARVE_LIMIT data grants.
  always_comb begin
    grant_inst_s = 1'b0;
    grant_data_s = 1'b0;
    if (reset) begin
      grant_inst_s = 1'b0;
      grant_data_s = 1'b0;
    end else begin
      grant_inst_s = inst_req & (~data_req | (starve_cnt_q == CNT_MAX));
      grant_data_s = data_req & ~grant_inst_s;
    end
  end

  // SRAM command mux from the granted side; all-zero when idle.
  always_comb begin
    sram_en    = 1'b0;
    sram_we    = {BE_W{1'b0}};
    sram_addr  = {ADDR_W{1'b0}};
    sram_wdata = {DATA_W{1'b0}};
    if (grant_inst_s) begin
      sram_en    = 1'b1;
      sram_we    = inst_we;
      sram_addr  = inst_addr;
      sram_wdata = inst_wdata;
    end else if (grant_data_s) begin
      sram_en    = 1'b1;
      sram_we    = data_we;
      sram_addr  = data_addr;
      sram_wdata = data_wdata;
    end else begin
      sram_en    = 1'b0;
    end
  end

  // Next-state for response tracking and the starvation counter.
  always_comb begin
    resp_valid_d = grant_inst_s | grant_data_s;
    resp_owner_d = grant_data_s;
    starve_cnt_d = starve_cnt_q;
    if (grant_inst_s || !inst_req) begin
      starve_cnt_d = {CNT_W{1'b0}};
    end else if (grant_data_s) begin
      if (starve_cnt_q != CNT_MAX) begin
        starve_cnt_d = starve_cnt_q + CNT_W'(1);
      end else begin
        starve_cnt_d = starve_cnt_q;
      end
    end else begin
      starve_cnt_d = starve_cnt_q;
    end
  end

  // State registers; reset drops any in-flight response.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid_q <= 1'b0;
      resp_owner_q <= 1'b0;
      starve_cnt_q <= {CNT_W{1'b0}};
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_owner_q <= resp_owner_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign inst_addr_ok = grant_inst_s;
  assign data_addr_ok = grant_data_s;
  // A response pending across a reset edge must never reach its requester.
  assign inst_data_ok = resp_valid_q & ~resp_owner_q & ~reset;
  assign data_data_ok = resp_valid_q &  resp_owner_q & ~reset;
  assign inst_rdata   = sram_rdata;
  assign data_rdata   = sram_rdata;

endmodule
